letc_core_amo_seq: RTL and testbench

//  Sequences RV32A AMO read-modify-write operations for the memory stages (M1/M2) of the LETC Core.
//  - Takes one AMO request, stalls the pipeline, and issues a word load on the shared data-memory port.
//  - Applies amo_alu_op_e to the loaded word and rs2, then issues the store.
//  - Returns the original memory word for writeback to rd. Plain loads/stores never enter this block.

---
 rtl/letc_core_pkg.sv | 45 ++++
 rtl/letc_core_amo_alu.sv | 31 +++
 rtl/letc_core_amo_seq.sv | 163 ++++++++++++++++
 tb/tb_letc_core_amo_seq.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/letc_core_pkg.sv
// Shared LETC core types: AMO ALU opcodes plus the AMO sequencer state and error-cause encodings.
// LETC_AMO_MINMAX_EN selects whether MIN/MAX/MINU/MAXU count as legal AMO operations.
package letc_core_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] vaddr_t;

    typedef enum logic [3:0] {
        AMO_OP_SWAP = 4'd0,
        AMO_OP_ADD  = 4'd1,
        AMO_OP_AND  = 4'd2,
        AMO_OP_OR   = 4'd3,
        AMO_OP_XOR  = 4'd4,
        AMO_OP_MIN  = 4'd5,
        AMO_OP_MAX  = 4'd6,
        AMO_OP_MINU = 4'd7,
        AMO_OP_MAXU = 4'd8
    } amo_alu_op_e;

    typedef enum logic [2:0] {
        AMO_SEQ_IDLE    = 3'd0,
        AMO_SEQ_RD_REQ  = 3'd1,
        AMO_SEQ_RD_WAIT = 3'd2,
        AMO_SEQ_WR_REQ  = 3'd3,
        AMO_SEQ_WR_WAIT = 3'd4,
        AMO_SEQ_DONE    = 3'd5,
        AMO_SEQ_ERR     = 3'd6
    } amo_seq_state_e;

    typedef enum logic [1:0] {
        AMO_ERR_MISALIGNED = 2'd0,
        AMO_ERR_TIMEOUT    = 2'd1,
        AMO_ERR_ILLEGAL    = 2'd2
    } amo_err_cause_e;

    function automatic logic amo_op_legal(input logic [3:0] op);
        logic legal;
        legal = (op <= AMO_OP_XOR);
`ifdef LETC_AMO_MINMAX_EN
        legal = (op <= AMO_OP_MAXU);
`endif
        return legal;
    endfunction

endpackage

// File: rtl/letc_core_amo_alu.sv
// Combinational AMO ALU: computes the word to store back from the old memory word and rs2.
// MIN/MAX comparators exist only when LETC_AMO_MINMAX_EN is defined.
module letc_core_amo_alu
    import letc_core_pkg::*;
(
    input  amo_alu_op_e op,
    input  word_t       old,
    input  word_t       rs2,
    output word_t       result
);

    always_comb begin
        result = old;
        case (op)
            AMO_OP_SWAP: result = rs2;
            AMO_OP_ADD:  result = old + rs2;
            AMO_OP_AND:  result = old & rs2;
            AMO_OP_OR:   result = old | rs2;
            AMO_OP_XOR:  result = old ^ rs2;
`ifdef LETC_AMO_MINMAX_EN
            // Strict compares so equal operands keep the old word.
            AMO_OP_MIN:  result = ($signed(rs2) < $signed(old)) ? rs2 : old;
            AMO_OP_MAX:  result = ($signed(rs2) > $signed(old)) ? rs2 : old;
            AMO_OP_MINU: result = (rs2 < old) ? rs2 : old;
            AMO_OP_MAXU: result = (rs2 > old) ? rs2 : old;
`endif
            default:     result = old;
        endcase
    end

endmodule

// File: rtl/letc_core_amo_seq.sv
// RV32A AMO read-modify-write sequencer for the M1/M2 stages; drives the shared data-memory port.
// LETC_AMO_MINMAX_EN enables the MIN/MAX family (otherwise they raise an illegal-op error).
//
// state   | meaning
// IDLE    | waiting for an AMO request from M1
// RD_REQ  | load request presented, waiting for req_ready
// RD_WAIT | waiting for load data
// WR_REQ  | store request presented, waiting for req_ready
// WR_WAIT | waiting for store ack
// DONE    | one-cycle completion pulse with old word
// ERR     | one-cycle error pulse with cause
module letc_core_amo_seq
    import letc_core_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    input  logic [3:0]  i_amo_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_rs2_val,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_mem_req_valid,
    input  logic        i_mem_req_ready,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_rsp_valid,
    input  logic [31:0] i_mem_rdata,
    output logic        o_done,
    output logic [31:0] o_rd_val,
    output logic        o_err,
    output logic [1:0]  o_err_cause
);

    localparam int unsigned TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] TIMER_LOAD = TIMEOUT_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;

    amo_seq_state_e state_q, state_d;
    amo_err_cause_e cause_q, cause_d;
    amo_alu_op_e    op_q, op_d;
    vaddr_t         addr_q, addr_d;
    word_t          rs2_q, rs2_d, old_q, old_d, new_q, new_d, alu_result;
    logic [TW-1:0]  timer_q, timer_d;
    logic           timed_out;

    letc_core_amo_alu u_alu (
        .op     (op_q),
        .old    (i_mem_rdata),
        .rs2    (rs2_q),
        .result (alu_result)
    );

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        op_d      = op_q;
        addr_d    = addr_q;
        rs2_d     = rs2_q;
        old_d     = old_q;
        new_d     = new_q;
        timer_d   = '0;
        // Down-counter loaded on entry to a wait state; terminal count at zero.
        timed_out = TIMEOUT_EN && (timer_q == '0);
        case (state_q)
            AMO_SEQ_IDLE: begin
                if (i_req_valid && !i_flush) begin
                    op_d   = amo_alu_op_e'(i_amo_op);
                    addr_d = i_addr;
                    rs2_d  = i_rs2_val;
                    if (i_addr[1:0] != 2'b00) begin
                        state_d = AMO_SEQ_ERR;
                        cause_d = AMO_ERR_MISALIGNED;
                    end else if (!amo_op_legal(i_amo_op)) begin
                        state_d = AMO_SEQ_ERR;
                        cause_d = AMO_ERR_ILLEGAL;
                    end else begin
                        state_d = AMO_SEQ_RD_REQ;
                    end
                end
            end
            AMO_SEQ_RD_REQ: begin
                // A flush coinciding with the handshake abandons the load; its response lands in IDLE.
                if (i_mem_req_ready) begin
                    state_d = i_flush ? AMO_SEQ_IDLE : AMO_SEQ_RD_WAIT;
                    timer_d = TIMER_LOAD;
                end else if (i_flush) begin
                    state_d = AMO_SEQ_IDLE;
                end
            end
            AMO_SEQ_RD_WAIT: begin
                if (i_flush) begin
                    state_d = AMO_SEQ_IDLE;
                end else if (i_mem_rsp_valid) begin
                    old_d   = i_mem_rdata;
                    new_d   = alu_result;
                    state_d = AMO_SEQ_WR_REQ;
                end else if (timed_out) begin
                    state_d = AMO_SEQ_ERR;
                    cause_d = AMO_ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            AMO_SEQ_WR_REQ: begin
                if (i_mem_req_ready) begin
                    state_d = AMO_SEQ_WR_WAIT;
                    timer_d = TIMER_LOAD;
                end
            end
            AMO_SEQ_WR_WAIT: begin
                if (i_mem_rsp_valid) begin
                    state_d = AMO_SEQ_DONE;
                end else if (timed_out) begin
                    state_d = AMO_SEQ_ERR;
                    cause_d = AMO_ERR_TIMEOUT;
                end else begin
                    timer_d = timer_q - TW'(1);
                end
            end
            AMO_SEQ_DONE: state_d = AMO_SEQ_IDLE;
            AMO_SEQ_ERR:  state_d = AMO_SEQ_IDLE;
            default:      state_d = AMO_SEQ_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= AMO_SEQ_IDLE;
            cause_q <= AMO_ERR_MISALIGNED;
            op_q    <= AMO_OP_SWAP;
            addr_q  <= '0;
            rs2_q   <= '0;
            old_q   <= '0;
            new_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            rs2_q   <= rs2_d;
            old_q   <= old_d;
            new_q   <= new_d;
            timer_q <= timer_d;
        end
    end

    assign o_stall         = i_req_valid && (state_q != AMO_SEQ_DONE) && (state_q != AMO_SEQ_ERR);
    assign o_mem_req_valid = (state_q == AMO_SEQ_RD_REQ) || (state_q == AMO_SEQ_WR_REQ);
    assign o_mem_we        = (state_q == AMO_SEQ_WR_REQ);
    assign o_mem_addr      = addr_q;
    assign o_mem_wdata     = new_q;
    assign o_done          = (state_q == AMO_SEQ_DONE);
    assign o_rd_val        = o_done ? old_q : '0;
    assign o_err           = (state_q == AMO_SEQ_ERR);
    assign o_err_cause     = o_err ? cause_q : 2'd0;

endmodule

// File: tb/tb_letc_core_amo_seq.sv
// Scoreboard bench for letc_core_amo_seq: directed AMO vectors, behavioural memory, decoupled monitor.
`timescale 1ns/1ps
module tb_letc_core_amo_seq;
    import letc_core_pkg::*;

`ifdef LETC_AMO_MINMAX_EN
    localparam bit MM = 1'b1;
`else
    localparam bit MM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, req_valid, flush;
    logic [3:0]  amo_op;
    logic [31:0] addr, rs2_val;
    logic        stall, mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid, done, err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, rd_val;
    logic [1:0]  err_cause;

    letc_core_amo_seq #(.TIMEOUT_CYCLES(4)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_amo_op(amo_op),
        .i_addr(addr), .i_rs2_val(rs2_val), .i_flush(flush), .o_stall(stall),
        .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready), .o_mem_we(mem_we),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .i_mem_rsp_valid(mem_rsp_valid),
        .i_mem_rdata(mem_rdata), .o_done(done), .o_rd_val(rd_val), .o_err(err),
        .o_err_cause(err_cause)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { bit is_err; logic [1:0] cause; logic [31:0] rd; } rsp_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } st_t;
    rsp_t rsp_q[$];
    st_t  st_q[$];

    int tests = 0, fails = 0;
    int n_req = 0, n_rd_hs = 0, n_wr_hs = 0;
    bit [31:0] mem [bit [31:0]];

    // memory model knobs
    bit rsp_en = 1'b1;
    int rsp_dly = 0;
    int wr_ready_dly = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done/err pulse.
    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && (done || err)) begin
                if (rsp_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_output: done=%0b err=%0b, want no output", done, err);
                end else begin
                    e = rsp_q.pop_front();
                    check("out_err", {31'b0, err}, {31'b0, e.is_err});
                    check("out_done", {31'b0, done}, {31'b0, !e.is_err});
                    if (e.is_err) check("err_cause", {30'b0, err_cause}, {30'b0, e.cause});
                    else          check("rd_val", rd_val, e.rd);
                end
            end
        end
    end

    // Behavioural data memory with handshake/response delays.
    initial begin
        bit        hs_now = 0, in_req = 0, rsp_pend = 0, l_we = 0, s_we = 0;
        bit [31:0] l_addr = 0, l_wdata = 0, s_addr = 0, s_wdata = 0, rsp_data = 0;
        int        wait_left = 0, rsp_wait = 0;
        st_t       es;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_rsp_valid = 1'b0; mem_rdata = '0;
            if (hs_now) begin
                hs_now = 0; mem_req_ready = 1'b0; n_req++;
                if (l_we) begin
                    n_wr_hs++;
                    if (st_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_store: addr 0x%08h data 0x%08h, want no store", l_addr, l_wdata);
                    end else begin
                        es = st_q.pop_front();
                        check("store_addr", l_addr, es.a);
                        check("store_data", l_wdata, es.d);
                    end
                    mem[l_addr] = l_wdata;
                end else begin
                    n_rd_hs++;
                end
                if (rsp_en) begin
                    rsp_pend = 1; rsp_wait = rsp_dly;
                    rsp_data = (!l_we && mem.exists(l_addr)) ? mem[l_addr] : 32'h0;
                end
            end
            if (rsp_pend) begin
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1'b1; mem_rdata = rsp_data; rsp_pend = 0;
                end else begin
                    rsp_wait--;
                end
            end
            if (mem_req_valid && !mem_req_ready && !hs_now) begin
                if (!in_req) begin
                    in_req = 1; wait_left = mem_we ? wr_ready_dly : 0;
                    s_addr = mem_addr; s_wdata = mem_wdata; s_we = mem_we;
                end else begin
                    check("hold_addr", mem_addr, s_addr);
                    check("hold_wdata", mem_wdata, s_wdata);
                    check("hold_we", {31'b0, mem_we}, {31'b0, s_we});
                    check("hold_stall", {31'b0, stall}, 32'd1);
                end
                if (wait_left == 0) begin
                    mem_req_ready = 1'b1; hs_now = 1; in_req = 0;
                    l_addr = mem_addr; l_wdata = mem_wdata; l_we = mem_we;
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // mode: 0 normal, 1 flush in RD_WAIT (no output expected), 2 flush in WR_WAIT
    task automatic run_amo(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] r2, input logic [31:0] old, input bit exp_err,
                           input logic [1:0] exp_cause, input logic [31:0] exp_new,
                           input int mode, input int exp_lat);
        int c0, req0, rd0, wr0;
        bit flushed = 0, fin = 0;
        rsp_t er;
        st_t  es;
        if (a[1:0] == 2'b00) mem[a] = old;
        if (mode != 1) begin
            er.is_err = exp_err; er.cause = exp_cause; er.rd = old;
            rsp_q.push_back(er);
            if (!exp_err) begin es.a = a; es.d = exp_new; st_q.push_back(es); end
        end
        req0 = n_req; rd0 = n_rd_hs; wr0 = n_wr_hs;
        @(negedge clk); #1;
        req_valid = 1'b1; amo_op = op; addr = a; rs2_val = r2; c0 = cyc;
        for (int i = 0; i < 100 && !fin; i++) begin
            @(negedge clk); #1;
            flush = 1'b0;
            if (mode == 1 && flushed) begin
                req_valid = 1'b0; fin = 1;
            end else if (done || err) begin
                req_valid = 1'b0; fin = 1;
                if (exp_lat >= 0) check({name, "_latency"}, cyc - c0, exp_lat);
            end else if (!flushed && ((mode == 1 && n_rd_hs != rd0) || (mode == 2 && n_wr_hs != wr0))) begin
                flush = 1'b1; flushed = 1;
            end
        end
        if (!fin) begin
            tests++; fails++; req_valid = 1'b0;
            $display("FAIL %s_wait: no done/err within 100 cycles, want completion", name);
        end
        if (exp_err && exp_cause != AMO_ERR_TIMEOUT) check({name, "_no_mem_req"}, n_req - req0, 0);
        if (mode == 1) begin
            repeat (8) @(negedge clk);
            check({name, "_no_store"}, n_wr_hs - wr0, 0);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0; amo_op = '0; addr = '0; rs2_val = '0;
        repeat (3) @(negedge clk);
        check("rst_mem_req_valid", {31'b0, mem_req_valid}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_stall", {31'b0, stall}, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_amo("add_basic",  AMO_OP_ADD,  32'h100, 32'd3,        32'd5,        0, 2'd0, 32'd8,        0, 5);
        run_amo("maxu",       AMO_OP_MAXU, 32'h104, 32'd1,        32'hFFFF_FFFF, !MM, 2'd2, 32'hFFFF_FFFF, 0, -1);
        run_amo("max",        AMO_OP_MAX,  32'h108, 32'd1,        32'hFFFF_FFFF, !MM, 2'd2, 32'd1,        0, -1);
        run_amo("min",        AMO_OP_MIN,  32'h10C, 32'd5,        32'hFFFF_FFFE, !MM, 2'd2, 32'hFFFF_FFFE, 0, -1);
        run_amo("minu",       AMO_OP_MINU, 32'h110, 32'd5,        32'hFFFF_FFFE, !MM, 2'd2, 32'd5,        0, -1);
        run_amo("max_equal",  AMO_OP_MAX,  32'h114, 32'd7,        32'd7,        !MM, 2'd2, 32'd7,        0, -1);
        run_amo("misaligned", AMO_OP_SWAP, 32'h102, 32'd1,        32'd0,        1, 2'd0, 32'd0,        0, 1);
        run_amo("illegal9",   4'd9,        32'h118, 32'd1,        32'd0,        1, 2'd2, 32'd0,        0, 1);
        run_amo("illegal15",  4'd15,       32'h11C, 32'd1,        32'd0,        1, 2'd2, 32'd0,        0, 1);
        run_amo("swap",       AMO_OP_SWAP, 32'h200, 32'h1234_5678, 32'hDEAD_BEEF, 0, 2'd0, 32'h1234_5678, 0, 5);
        run_amo("and",        AMO_OP_AND,  32'h204, 32'h0FF0_0F0F, 32'hF0F0_FF00, 0, 2'd0, 32'h00F0_0F00, 0, -1);
        run_amo("or",         AMO_OP_OR,   32'h208, 32'h0FF0_0F0F, 32'hF0F0_FF00, 0, 2'd0, 32'hFFF0_FF0F, 0, -1);
        run_amo("xor",        AMO_OP_XOR,  32'h20C, 32'h0FF0_0F0F, 32'hF0F0_FF00, 0, 2'd0, 32'hFF00_F00F, 0, -1);
        run_amo("add_wrap",   AMO_OP_ADD,  32'h210, 32'd2,        32'hFFFF_FFFF, 0, 2'd0, 32'd1,        0, -1);

        rsp_dly = 2;
        run_amo("flush_rd",   AMO_OP_ADD,  32'h300, 32'd1,        32'd1,        0, 2'd0, 32'd2,        1, -1);
        run_amo("flush_wr",   AMO_OP_ADD,  32'h304, 32'd20,       32'd10,       0, 2'd0, 32'd30,       2, -1);
        rsp_dly = 0;
        run_amo("after_flush", AMO_OP_XOR, 32'h308, 32'h0000_00FF, 32'h0000_0F0F, 0, 2'd0, 32'h0000_0FF0, 0, 5);

        rsp_en = 1'b0;
        begin
            int wr0;
            wr0 = n_wr_hs;
            run_amo("timeout", AMO_OP_XOR, 32'h30C, 32'd1, 32'd0, 1, 2'd1, 32'd0, 0, 6);
            check("timeout_no_store", n_wr_hs - wr0, 0);
        end
        rsp_en = 1'b1;

        wr_ready_dly = 10;
        run_amo("wr_stall",   AMO_OP_OR,   32'h310, 32'h0000_000F, 32'h0000_00F0, 0, 2'd0, 32'h0000_00FF, 0, 15);
        wr_ready_dly = 0;

        repeat (4) @(negedge clk);
        check("sb_rsp_empty", rsp_q.size(), 0);
        check("sb_store_empty", st_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
